regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Round-robin arbiter that shares the single register-file write port among eight requesters (ALU, load unit, CSR path, etc.). Each cycle it picks at most one pending requester, forwards that requester's address and data to the register file as a registered one-cycle write, and returns a one-hot grant. It sits between the execute/writeback sources and the register file, and drives the register file's write enable through its one-hot grant decode.

## Interface
- DATA_W, 16, register data width
- N_REQ, 8, number of requesters (fixed; index width 3)
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- Enable  input  1  arbitration enable; 0 blocks new grants
- Req  input  8  per-requester write request, bit i = requester i
- Req_Addr  input  24  packed destination register indices, bits [3i+2:3i] = requester i
- Req_Data  input  128  packed write data, bits [16i+15:16i] = requester i
- Lock  input  8  per-requester burst hold (used only with ARB_LOCK_EN)
- Gnt  output  8  one-hot grant, registered
- Gnt_Idx  output  3  binary index of granted requester
- Wr_En  output  1  register-file write enable
- Wr_Addr  output  3  register-file write address
- Wr_Data  output  16  register-file write data

## Operation
- Reset value of every output is 0; round-robin pointer Ptr = 0; state = IDLE.
- Eligible set E = Req & ~Gnt, so a requester granted this cycle cannot win the next cycle unless locked.
- Winner: the first set bit of E, searching upward from Ptr and wrapping 7 -> 0.
- At each edge with Enable=1 and E≠0: Gnt = one-hot(winner), Gnt_Idx = winner, Wr_En = 1, Wr_Addr/Wr_Data = winner's slices; Ptr = (winner+1) mod 8 (7 wraps to 0).
- At each edge with Enable=0 or E=0: Gnt, Wr_En = 0; Wr_Addr, Wr_Data and Gnt_Idx hold their previous values; Ptr unchanged.
- Requester protocol: hold Req/Addr/Data stable until Gnt[i] is seen high; the write is committed in that Gnt cycle. Drop or re-present Req in the Gnt cycle; a re-presented request is eligible one cycle later.
- States:
  - IDLE: no grant.
  - GRANT: one-cycle grant; go to GRANT again (new winner) or IDLE per the rules above.
  - LOCK: exists only with ARB_LOCK_EN.
- Changes to Enable take effect at the next edge. A grant already being driven completes, because outputs are registered.
- RST asserted mid-grant clears all outputs immediately (asynchronously). The pending write is lost; requesters re-request after reset.

## Timing
- Latency: Req sampled at edge N, with Gnt/Wr_En high during cycle N+1 (1 cycle).
- Throughput: 1 write/cycle aggregate. A single unlocked requester gets at most every other cycle.
- Worst-case wait for a continuously requesting source: 7 grants to other requesters.
- No combinational path from inputs to outputs.

## Configuration
- ARB_LOCK_EN defined:
  - A winner with Lock[i]=1 enters LOCK.
  - While in LOCK, Req[i] & Lock[i] re-grants i every cycle, exempt from the ~Gnt mask; Ptr is frozen.
  - Release happens on the first edge where Req[i] & Lock[i] = 0. At release, Ptr = i+1 and normal arbitration runs on that same edge.
  - Enable=0 also releases LOCK.
- ARB_LOCK_EN undefined: Lock is ignored and the LOCK state is not built.

## Structure
- Shared package: N_REQ, IDX_W=3, DATA_W=16, and the state encoding (IDLE=2'd0, GRANT=2'd1, LOCK=2'd2).
- Sub-module: three_to_eight_decoder, instantiated with Enable tied to the "grant valid" term, to turn the winner index into the one-hot Gnt. The round-robin search stays in this block.

## Test plan
- Reset then idle: RST pulse, Req=0 for 5 cycles -> all outputs 0, Ptr=0.
- Single request: Req=8'b0000_0100, Addr2=3'd5, Data2=16'hBEEF, held -> Gnt=8'b0000_0100 and Wr_En=1 with Wr_Addr=5, Wr_Data=BEEF one cycle later; if Req stays high, grants on alternate cycles only.
- Round-robin fairness: Req=8'hFF held for 16 cycles -> Gnt_Idx sequence 0,1,2,...,7,0,... with no repeats inside any 8-grant window; Ptr wraps from 7 to 0.
- Enable gating: Req=8'h81, Enable=0 for 3 cycles then 1 -> no Gnt while disabled; then index 0 granted, then index 7.
- Reset mid-grant: assert RST in the cycle Gnt=8'h10 -> Gnt, Wr_En drop to 0 without waiting for CLK, Ptr=0; after release with Req=8'h10, index 4 is granted after 1 cycle.
- Lock (ARB_LOCK_EN): Req=8'h06, Lock=8'h02 for 4 cycles -> index 1 granted 4 consecutive cycles; on the cycle Lock drops, index 2 is granted.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_write_arbiter_pkg: shared widths, FSM encoding and round-robin search helper.
// Rev 1.0
`default_nettype none

package regfile_write_arbiter_pkg;

  localparam int N_REQ  = 8;
  localparam int IDX_W  = 3;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    LOCK  = 2'd2
  } arb_state_t;

  // Returns {found, index} of the first set bit of elig at or above ptr, wrapping.
  // Scanning from the farthest offset down leaves the nearest hit as the final value.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] elig,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    rr_pick = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (elig[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_write_arbiter_decoder.sv
// three_to_eight_decoder: index to one-hot, all zeros when not enabled.
// Rev 1.0
`default_nettype none

module three_to_eight_decoder
  import regfile_write_arbiter_pkg::*;
(
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin owner of the register-file write port.
// Rev 1.0 -- optional burst hold built when ARB_LOCK_EN is defined.
`default_nettype none

module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    Enable,
  input  logic [N_REQ-1:0]        Req,
  input  logic [N_REQ*IDX_W-1:0]  Req_Addr,
  input  logic [N_REQ*DATA_W-1:0] Req_Data,
  input  logic [N_REQ-1:0]        Lock,
  output logic [N_REQ-1:0]        Gnt,
  output logic [IDX_W-1:0]        Gnt_Idx,
  output logic                    Wr_En,
  output logic [IDX_W-1:0]        Wr_Addr,
  output logic [DATA_W-1:0]       Wr_Data
);

  arb_state_t        state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W:0]    pick;
  logic              locked_hold;
  logic              grant_valid;
  logic [IDX_W-1:0]  win_idx;
  logic [N_REQ-1:0]  gnt_dec;
  logic [IDX_W-1:0]  addr_arr [N_REQ];
  logic [DATA_W-1:0] data_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addr_arr[i] = Req_Addr[i*IDX_W +: IDX_W];
    assign data_arr[i] = Req_Data[i*DATA_W +: DATA_W];
  end

  // Masking with the current grant keeps a lone requester to alternate cycles.
  assign pick = rr_pick(Req & ~Gnt, ptr);

`ifdef ARB_LOCK_EN
  assign locked_hold = (state == LOCK) && Enable && Req[Gnt_Idx] && Lock[Gnt_Idx];
`else
  logic unused_bits;
  assign locked_hold = 1'b0;
  assign unused_bits = ^{Lock, state};
`endif

  assign win_idx     = locked_hold ? Gnt_Idx : pick[IDX_W-1:0];
  assign grant_valid = locked_hold || (Enable && pick[IDX_W]);

  three_to_eight_decoder u_dec (
    .en     (grant_valid),
    .idx    (win_idx),
    .onehot (gnt_dec)
  );

  // Pointer already sits at winner+1 on entry to LOCK, so freezing it yields the release value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      ptr     <= '0;
      Gnt     <= '0;
      Gnt_Idx <= '0;
      Wr_En   <= 1'b0;
      Wr_Addr <= '0;
      Wr_Data <= '0;
    end else begin
      Gnt   <= gnt_dec;
      Wr_En <= grant_valid;
      if (grant_valid) begin
        Gnt_Idx <= win_idx;
        Wr_Addr <= addr_arr[win_idx];
        Wr_Data <= data_arr[win_idx];
        if (!locked_hold) ptr <= win_idx + 1'b1;
`ifdef ARB_LOCK_EN
        state <= Lock[win_idx] ? LOCK : GRANT;
`else
        state <= GRANT;
`endif
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: randomized and directed checks against a behavioural arbiter model.
// Rev 1.0
`default_nettype none

module tb_regfile_write_arbiter;

  logic         CLK = 1'b0;
  logic         RST;
  logic         Enable;
  logic [7:0]   Req;
  logic [23:0]  Req_Addr;
  logic [127:0] Req_Data;
  logic [7:0]   Lock;
  logic [7:0]   Gnt;
  logic [2:0]   Gnt_Idx;
  logic         Wr_En;
  logic [2:0]   Wr_Addr;
  logic [15:0]  Wr_Data;

  int n_vec  = 0;
  int n_miss = 0;
  logic chk_on = 1'b0;

  logic [7:0]  m_gnt;
  int          m_idx;
  logic        m_we;
  logic [2:0]  m_addr;
  logic [15:0] m_data;
  int          m_ptr;
  logic        m_locked;

  regfile_write_arbiter dut (
    .CLK      (CLK),
    .RST      (RST),
    .Enable   (Enable),
    .Req      (Req),
    .Req_Addr (Req_Addr),
    .Req_Data (Req_Data),
    .Lock     (Lock),
    .Gnt      (Gnt),
    .Gnt_Idx  (Gnt_Idx),
    .Wr_En    (Wr_En),
    .Wr_Addr  (Wr_Addr),
    .Wr_Data  (Wr_Data)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pick the first eligible requester walking upward from the pointer.
  always @(posedge CLK or posedge RST) begin : model
    logic [7:0] elig;
    int         win;
    int         j;
    logic       hold;
    if (RST) begin
      m_gnt <= '0; m_idx <= 0; m_we <= 1'b0; m_addr <= '0;
      m_data <= '0; m_ptr <= 0; m_locked <= 1'b0;
    end else begin
      win  = -1;
      hold = 1'b0;
      elig = Req & ~m_gnt;
`ifdef ARB_LOCK_EN
      if (m_locked && Enable && Req[m_idx] && Lock[m_idx]) begin
        win  = m_idx;
        hold = 1'b1;
      end
`endif
      if (win < 0 && Enable) begin
        for (int k = 0; k < 8; k++) begin
          j = (m_ptr + k) % 8;
          if (win < 0 && elig[j]) win = j;
        end
      end
      if (win >= 0) begin
        m_gnt  <= 8'b1 << win;
        m_idx  <= win;
        m_we   <= 1'b1;
        m_addr <= Req_Addr[win*3 +: 3];
        m_data <= Req_Data[win*16 +: 16];
        if (!hold) m_ptr <= (win + 1) % 8;
`ifdef ARB_LOCK_EN
        m_locked <= Lock[win];
`else
        m_locked <= 1'b0;
`endif
      end else begin
        m_gnt    <= '0;
        m_we     <= 1'b0;
        m_locked <= 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      check("gnt",     {24'd0, Gnt},     {24'd0, m_gnt});
      check("gnt_idx", {29'd0, Gnt_Idx}, 32'(m_idx));
      check("wr_en",   {31'd0, Wr_En},   {31'd0, m_we});
      check("wr_addr", {29'd0, Wr_Addr}, {29'd0, m_addr});
      check("wr_data", {16'd0, Wr_Data}, {16'd0, m_data});
    end
  end

  initial begin
    RST = 1'b1; Enable = 1'b1; Req = '0; Req_Addr = '0; Req_Data = '0; Lock = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    chk_on = 1'b1;

    // Reset then idle
    repeat (5) begin
      @(negedge CLK);
      check("idle_gnt", {24'd0, Gnt}, 32'h0);
      check("idle_we",  {31'd0, Wr_En}, 32'h0);
    end
    check("idle_data", {16'd0, Wr_Data}, 32'h0);

    // Single request, held: grants alternate
    Req = 8'h04; Req_Addr = 24'd5 << 6; Req_Data = 128'hBEEF << 32;
    @(negedge CLK);
    check("single_gnt",  {24'd0, Gnt}, 32'h04);
    check("single_we",   {31'd0, Wr_En}, 32'h1);
    check("single_addr", {29'd0, Wr_Addr}, 32'd5);
    check("single_data", {16'd0, Wr_Data}, 32'hBEEF);
    @(negedge CLK);
    check("single_gap",  {24'd0, Gnt}, 32'h0);
    check("single_hold", {29'd0, Wr_Addr}, 32'd5);
    @(negedge CLK);
    check("single_again", {24'd0, Gnt}, 32'h04);

    // Round-robin fairness from a fresh pointer
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0; Req = 8'hFF;
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK);
      check("rr_idx", {29'd0, Gnt_Idx}, 32'(k % 8));
      check("rr_gnt", {24'd0, Gnt}, 32'(1) << (k % 8));
    end

    // Enable gating
    Enable = 1'b0; Req = 8'h81;
    repeat (3) begin
      @(negedge CLK);
      check("dis_gnt", {24'd0, Gnt}, 32'h0);
    end
    Enable = 1'b1;
    @(negedge CLK);
    check("en_idx0", {29'd0, Gnt_Idx}, 32'd0);
    @(negedge CLK);
    check("en_idx7", {29'd0, Gnt_Idx}, 32'd7);

    // Asynchronous reset mid-grant
    Req = 8'h10;
    @(negedge CLK);
    check("pre_rst_gnt", {24'd0, Gnt}, 32'h10);
    #1 RST = 1'b1;
    #1;
    check("async_gnt", {24'd0, Gnt}, 32'h0);
    check("async_we",  {31'd0, Wr_En}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_idx", {29'd0, Gnt_Idx}, 32'd4);
    check("post_rst_gnt", {24'd0, Gnt}, 32'h10);
    Req = '0;
    @(negedge CLK);

`ifdef ARB_LOCK_EN
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0; Req = 8'h06; Lock = 8'h02;
    repeat (4) begin
      @(negedge CLK);
      check("lock_idx", {29'd0, Gnt_Idx}, 32'd1);
    end
    Lock = 8'h00;
    @(negedge CLK);
    check("unlock_idx", {29'd0, Gnt_Idx}, 32'd2);
    Req = '0;
    @(negedge CLK);
`endif

    // Randomized traffic; requests mostly held until granted
    for (int c = 0; c < 600; c++) begin
      @(negedge CLK);
      Req      = (Req & ~Gnt) | 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) Req = 8'($urandom);
      Enable   = ($urandom_range(0, 7) != 0);
      Lock     = 8'($urandom) & 8'($urandom);
      Req_Addr = 24'($urandom);
      Req_Data = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 199) == 0) RST = 1'b1;
      else RST = 1'b0;
    end
    RST = 1'b0;
    @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
